// File: rtl/ram_port_arbiter.sv
// ============================================================================
// Module   : ram_port_arbiter
// Purpose  : Shares one RAM port between instruction fetch and data memory.
//            Optional fetch-fairness streak limit: define ARB_FAIRNESS_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ram_port_arbiter #(
  parameter int MAX_DSTREAK = 4,
  parameter int ADDR_W      = 32
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              iREN,
  input  logic [ADDR_W-1:0] iaddr,
  input  logic              dREN,
  input  logic              dWEN,
  input  logic [ADDR_W-1:0] daddr,
  input  logic [ADDR_W-1:0] dstore,
  input  logic [1:0]        ramstate,
  input  logic [ADDR_W-1:0] ramload,
  output logic              ramREN,
  output logic              ramWEN,
  output logic [ADDR_W-1:0] ramaddr,
  output logic [ADDR_W-1:0] ramstore,
  output logic              iwait,
  output logic              dwait,
  output logic [ADDR_W-1:0] iload,
  output logic [ADDR_W-1:0] dload
);

  localparam logic [1:0] c_IDLE   = 2'd0;
  localparam logic [1:0] c_IGRANT = 2'd1;
  localparam logic [1:0] c_DGRANT = 2'd2;

  localparam logic [1:0] c_RAM_ACCESS = 2'd2;
  localparam logic [1:0] c_RAM_ERROR  = 2'd3;

  logic [1:0] r_state;
  logic [1:0] w_next_state;
  logic       w_dreq;
  logic       w_access;
  logic       w_error;
  logic       w_force_i;
  logic       w_i_done;
  logic       w_d_done;

  assign w_dreq   = dREN | dWEN;
  assign w_access = (ramstate == c_RAM_ACCESS);
  assign w_error  = (ramstate == c_RAM_ERROR);
  assign w_i_done = (r_state == c_IGRANT) && iREN && w_access;
  assign w_d_done = (r_state == c_DGRANT) && w_dreq && w_access;

`ifdef ARB_FAIRNESS_EN
  localparam int               c_SW         = $clog2(MAX_DSTREAK + 1);
  localparam logic [c_SW-1:0] c_MAX_STREAK = c_SW'(MAX_DSTREAK);

  logic [c_SW-1:0] r_streak;

  // Counts back-to-back data completions that starved a waiting fetch.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_streak <= '0;
    end else if (w_i_done || (w_d_done && !iREN)) begin
      r_streak <= '0;
    end else if (w_d_done && iREN && (r_streak < c_MAX_STREAK)) begin
      r_streak <= r_streak + 1'b1;
    end
  end

  assign w_force_i = iREN && (r_streak >= c_MAX_STREAK);
`else
  // Constant-false; keeps the parameter referenced in the fixed-priority build.
  assign w_force_i = (MAX_DSTREAK < 0) && iREN;
`endif

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state <= c_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      c_IDLE: begin
        if (w_dreq && !w_force_i) begin
          w_next_state = c_DGRANT;
        end else if (iREN) begin
          w_next_state = c_IGRANT;
        end
      end
      c_IGRANT: begin
        if (!iREN || w_access || w_error) begin
          w_next_state = c_IDLE;
        end
      end
      c_DGRANT: begin
        if (!w_dreq || w_access || w_error) begin
          w_next_state = c_IDLE;
        end
      end
      default: w_next_state = c_IDLE;
    endcase
  end

  always_comb begin
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    iwait    = iREN;
    dwait    = w_dreq;
    iload    = '0;
    dload    = '0;
    case (r_state)
      c_IGRANT: begin
        if (iREN) begin
          ramREN  = 1'b1;
          ramaddr = iaddr;
          iwait   = !w_access;
          iload   = w_access ? ramload : '0;
        end
      end
      c_DGRANT: begin
        // A write wins over a simultaneous read.
        if (w_dreq) begin
          ramWEN   = dWEN;
          ramREN   = !dWEN;
          ramaddr  = daddr;
          ramstore = dstore;
          dwait    = !w_access;
          dload    = w_access ? ramload : '0;
        end
      end
      default: ;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_ram_port_arbiter.sv
// ============================================================================
// Module   : tb_ram_port_arbiter
// Purpose  : Directed self-checking bench for ram_port_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ram_port_arbiter;

  localparam int ADDR_W = 32;

  logic              CLK;
  logic              nRST;
  logic              iREN;
  logic [ADDR_W-1:0] iaddr;
  logic              dREN;
  logic              dWEN;
  logic [ADDR_W-1:0] daddr;
  logic [ADDR_W-1:0] dstore;
  logic [1:0]        ramstate;
  logic [ADDR_W-1:0] ramload;
  logic              ramREN;
  logic              ramWEN;
  logic [ADDR_W-1:0] ramaddr;
  logic [ADDR_W-1:0] ramstore;
  logic              iwait;
  logic              dwait;
  logic [ADDR_W-1:0] iload;
  logic [ADDR_W-1:0] dload;

  int n_compared;
  int n_mismatched;

  ram_port_arbiter #(
    .MAX_DSTREAK(4),
    .ADDR_W     (ADDR_W)
  ) u_dut (
    .CLK     (CLK),
    .nRST    (nRST),
    .iREN    (iREN),
    .iaddr   (iaddr),
    .dREN    (dREN),
    .dWEN    (dWEN),
    .daddr   (daddr),
    .dstore  (dstore),
    .ramstate(ramstate),
    .ramload (ramload),
    .ramREN  (ramREN),
    .ramWEN  (ramWEN),
    .ramaddr (ramaddr),
    .ramstore(ramstore),
    .iwait   (iwait),
    .dwait   (dwait),
    .iload   (iload),
    .dload   (dload)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic t_check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Inputs are driven 1 time unit after the rising edge; outputs sampled 1 unit later.
  task automatic t_tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic t_settle();
    #1;
  endtask

  task automatic t_quiet();
    iREN     = 1'b0;
    dREN     = 1'b0;
    dWEN     = 1'b0;
    ramstate = 2'd0;
    ramload  = '0;
  endtask

  int d_cnt;
  int i_cnt;
  logic [4:0] order;

  initial begin
    n_compared   = 0;
    n_mismatched = 0;
    nRST   = 1'b0;
    iaddr  = 32'h100;
    daddr  = '0;
    dstore = '0;
    t_quiet();

    // 1: reset, then instruction fetch with two BUSY cycles
    iREN     = 1'b1;
    ramstate = 2'd1;
    #3;
    t_check("rst_ramREN", 32'(ramREN), 32'd0);
    t_check("rst_ramWEN", 32'(ramWEN), 32'd0);
    t_check("rst_ramaddr", ramaddr, 32'd0);
    t_check("rst_iwait", 32'(iwait), 32'd1);
    t_check("rst_dwait", 32'(dwait), 32'd0);
    t_check("rst_iload", iload, 32'd0);
    t_tick();
    nRST = 1'b1;
    t_settle();
    t_check("t1_idle_ramREN", 32'(ramREN), 32'd0);
    t_check("t1_idle_iwait", 32'(iwait), 32'd1);
    t_tick();
    t_settle();
    t_check("t1_busy1_ramREN", 32'(ramREN), 32'd1);
    t_check("t1_busy1_ramaddr", ramaddr, 32'h100);
    t_check("t1_busy1_iwait", 32'(iwait), 32'd1);
    t_tick();
    t_settle();
    t_check("t1_busy2_iwait", 32'(iwait), 32'd1);
    t_tick();
    ramstate = 2'd2;
    ramload  = 32'h8C010004;
    t_settle();
    t_check("t1_acc_iwait", 32'(iwait), 32'd0);
    t_check("t1_acc_iload", iload, 32'h8C010004);
    t_check("t1_acc_dload", dload, 32'd0);
    t_tick();
    t_quiet();
    t_settle();
    t_check("t1_after_ramREN", 32'(ramREN), 32'd0);

    // 2: simultaneous fetch and data read; data wins, fetch follows after one idle cycle
    iREN  = 1'b1;
    iaddr = 32'h104;
    dREN  = 1'b1;
    daddr = 32'h200;
    t_settle();
    t_check("t2_idle_ramREN", 32'(ramREN), 32'd0);
    t_check("t2_idle_dwait", 32'(dwait), 32'd1);
    t_tick();
    ramstate = 2'd1;
    t_settle();
    t_check("t2_dg_ramREN", 32'(ramREN), 32'd1);
    t_check("t2_dg_ramaddr", ramaddr, 32'h200);
    t_check("t2_dg_iwait", 32'(iwait), 32'd1);
    t_tick();
    ramstate = 2'd2;
    ramload  = 32'h55;
    t_settle();
    t_check("t2_dacc_dwait", 32'(dwait), 32'd0);
    t_check("t2_dacc_dload", dload, 32'h55);
    t_check("t2_dacc_iload", iload, 32'd0);
    t_check("t2_dacc_iwait", 32'(iwait), 32'd1);
    t_tick();
    dREN     = 1'b0;
    ramstate = 2'd0;
    t_settle();
    t_check("t2_turn_ramREN", 32'(ramREN), 32'd0);
    t_check("t2_turn_iwait", 32'(iwait), 32'd1);
    t_tick();
    t_settle();
    t_check("t2_ig_ramREN", 32'(ramREN), 32'd1);
    t_check("t2_ig_ramaddr", ramaddr, 32'h104);
    ramstate = 2'd2;
    t_settle();
    t_check("t2_iacc_iwait", 32'(iwait), 32'd0);
    t_tick();
    t_quiet();

    // 3: write and read together; write wins
    dWEN     = 1'b1;
    dREN     = 1'b1;
    daddr    = 32'h300;
    dstore   = 32'hDEADBEEF;
    ramstate = 2'd1;
    t_tick();
    t_settle();
    t_check("t3_ramWEN", 32'(ramWEN), 32'd1);
    t_check("t3_ramREN", 32'(ramREN), 32'd0);
    t_check("t3_ramstore", ramstore, 32'hDEADBEEF);
    t_check("t3_ramaddr", ramaddr, 32'h300);
    t_check("t3_busy_dwait", 32'(dwait), 32'd1);
    ramstate = 2'd2;
    t_settle();
    t_check("t3_acc_dwait", 32'(dwait), 32'd0);
    t_tick();
    t_quiet();

    // 4: ERROR during fetch forces a retry through IDLE
    iREN  = 1'b1;
    iaddr = 32'h180;
    t_tick();
    ramstate = 2'd3;
    t_settle();
    t_check("t4_err_ramREN", 32'(ramREN), 32'd1);
    t_check("t4_err_iwait", 32'(iwait), 32'd1);
    t_tick();
    ramstate = 2'd0;
    t_settle();
    t_check("t4_idle_ramREN", 32'(ramREN), 32'd0);
    t_check("t4_idle_iwait", 32'(iwait), 32'd1);
    t_tick();
    t_settle();
    t_check("t4_retry_ramREN", 32'(ramREN), 32'd1);
    t_check("t4_retry_ramaddr", ramaddr, 32'h180);
    ramstate = 2'd2;
    t_settle();
    t_check("t4_retry_iwait", 32'(iwait), 32'd0);
    t_tick();
    t_quiet();

    // 5: asynchronous reset in the middle of a data grant
    dREN     = 1'b1;
    daddr    = 32'h240;
    ramstate = 2'd1;
    t_tick();
    t_settle();
    t_check("t5_dg_ramREN", 32'(ramREN), 32'd1);
    #2;
    nRST = 1'b0;
    #1;
    t_check("t5_rst_ramREN", 32'(ramREN), 32'd0);
    t_check("t5_rst_ramWEN", 32'(ramWEN), 32'd0);
    t_check("t5_rst_dwait", 32'(dwait), 32'd1);
    nRST = 1'b1;
    #1;
    t_check("t5_rel_ramREN", 32'(ramREN), 32'd0);
    t_tick();
    t_settle();
    t_check("t5_rearb_ramREN", 32'(ramREN), 32'd1);
    t_check("t5_rearb_ramaddr", ramaddr, 32'h240);
    ramstate = 2'd2;
    t_tick();
    t_quiet();

    // 6: sustained data traffic against a waiting fetch
    dREN     = 1'b1;
    iREN     = 1'b1;
    ramstate = 2'd2;
    t_settle();
    d_cnt = 0;
    i_cnt = 0;
    order = '0;
`ifdef ARB_FAIRNESS_EN
    for (int c = 0; c < 20 && (d_cnt + i_cnt) < 5; c++) begin
      if (!dwait) begin
        d_cnt++;
      end
      if (!iwait) begin
        order[d_cnt + i_cnt] = 1'b1;
        i_cnt++;
      end
      t_tick();
      t_settle();
    end
    t_check("t6_total", 32'(d_cnt + i_cnt), 32'd5);
    t_check("t6_order", 32'(order), 32'h10);
    t_check("t6_icnt", 32'(i_cnt), 32'd1);
`else
    for (int c = 0; c < 10; c++) begin
      if (!dwait) begin
        d_cnt++;
      end
      if (!iwait) begin
        i_cnt++;
      end
      t_tick();
      t_settle();
    end
    t_check("t6_dcnt", 32'(d_cnt), 32'd5);
    t_check("t6_icnt", 32'(i_cnt), 32'd0);
`endif
    t_quiet();
    t_tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: bench did not reach its end");
    $fatal(1);
  end

endmodule

`default_nettype wire

// File: doc/ram_port_arbiter.md
Name: ram_port_arbiter

Overview:
- Shares the single unified RAM port between the instruction-fetch requester (driven by the PC address) and the data-memory requester of one core.
- Grants one requester at a time and holds the grant until the RAM reports completion.
- Returns wait and load data to the owning requester only.
- Sits between the fetch/memory stages and the RAM controller.

Parameters:
- MAX_DSTREAK, 4: consecutive data grants allowed while a fetch is pending. Used only with the optional feature.
- ADDR_W, 32: address, store-data and load-data width.

Ports:
- CLK  in  1  clock
- nRST  in  1  asynchronous active-low reset
- iREN  in  1  instruction read request
- iaddr  in  ADDR_W  instruction address (PC)
- dREN  in  1  data read request
- dWEN  in  1  data write request
- daddr  in  ADDR_W  data address
- dstore  in  ADDR_W  data write value
- ramstate  in  2  RAM status: 0 FREE, 1 BUSY, 2 ACCESS, 3 ERROR
- ramload  in  ADDR_W  RAM read data
- ramREN  out  1  RAM read enable
- ramWEN  out  1  RAM write enable
- ramaddr  out  ADDR_W  RAM address
- ramstore  out  ADDR_W  RAM write data
- iwait  out  1  fetch not complete this cycle
- dwait  out  1  data access not complete this cycle
- iload  out  ADDR_W  instruction data
- dload  out  ADDR_W  data load value

Behaviour:
- Clock and reset: one clock CLK; reset nRST is asynchronous, active-low.
- Reset: FSM to IDLE, streak counter to 0.
- Outputs during and after reset, until a grant: ramREN=0, ramWEN=0, ramaddr=0, ramstore=0, iwait=iREN, dwait=(dREN|dWEN), iload=0, dload=0.
- States: IDLE, IGRANT, DGRANT. State is registered; all outputs are combinational from state, requests and ramstate.
- IDLE arbitration:
  - (dREN|dWEN) -> DGRANT.
  - Otherwise iREN -> IGRANT.
  - Otherwise stay in IDLE.
  - Data has fixed priority.
  - No RAM enables are driven in IDLE.
- IGRANT: ramREN=1, ramaddr=iaddr, ramWEN=0.
- DGRANT:
  - ramaddr=daddr, ramstore=dstore.
  - dWEN=1 -> ramWEN=1, ramREN=0. dWEN has priority over dREN when both are high.
  - Otherwise ramREN=1.
- Completion:
  - In a grant state with ramstate==ACCESS, the owner's wait is 0 in that same cycle.
  - In that cycle the owner's load is ramload; the non-owner's load is 0.
  - Next state is IDLE, giving a one-cycle turnaround before the next grant.
- Owner's wait = !(ramstate==ACCESS) while granted. Non-owner's wait = its request signal.
- ERROR: treated as not complete. The owner's wait stays 1 and the FSM returns to IDLE; the requester is re-arbitrated, which retries the access.
- Owner drops its request (iREN, or dREN|dWEN, falls) before ACCESS: the same cycle drives no RAM enables; the FSM returns to IDLE next cycle.
- FREE and BUSY: hold the grant and the outputs stable.
- Address and data pass through combinationally while granted. The requester must hold them stable until its wait drops.
- Reset mid-access: asynchronous return to IDLE and RAM enables deasserted immediately. The RAM controller tolerates the abort.

Optional Feature:
- Macro: ARB_FAIRNESS_EN.
- Enabled:
  - The streak counter increments on each DGRANT completion while iREN=1.
  - The counter clears on IGRANT completion, or when a data grant completes with iREN=0.
  - When streak>=MAX_DSTREAK and iREN=1, IDLE picks IGRANT even if a data request is present.
  - The counter saturates at MAX_DSTREAK.
- Disabled: no counter logic; fixed data priority only.

Test Plan:
1. Reset with iREN=1, iaddr=0x100, ramstate=BUSY for 2 cycles then ACCESS, ramload=0x8C010004 -> IGRANT one cycle after reset, ramREN=1, ramaddr=0x100, iwait low only in the ACCESS cycle, iload=0x8C010004.
2. iREN=1 and dREN=1 (daddr=0x200) together in IDLE -> DGRANT first, ramaddr=0x200, iwait=1 throughout. After dwait drops: one IDLE cycle, then IGRANT with ramaddr=iaddr.
3. dWEN=1 and dREN=1, daddr=0x300, dstore=0xDEADBEEF -> ramWEN=1, ramREN=0, ramstore=0xDEADBEEF; dwait falls on ACCESS.
4. IGRANT with ramstate=ERROR for 1 cycle -> iwait stays 1, FSM goes to IDLE, then IGRANT is re-issued with the same iaddr.
5. nRST pulsed low mid-DGRANT while ramstate=BUSY -> ramREN and ramWEN go to 0 asynchronously; after release the FSM is in IDLE and re-arbitrates.
6. With ARB_FAIRNESS_EN, MAX_DSTREAK=4, dREN and iREN held high -> exactly 4 data completions, then 1 instruction completion. Without the macro, iwait stays 1 while dREN is held.
